// File: rtl/rca_acc_pkg.sv
// Shared types and constants for the rca_acc_64bit accumulator stage.
// Optional build macro used by the stage: RCA_ACC_SATURATE_EN.
package rca_acc_pkg;

    // Accumulator FSM: collecting operands, or holding a finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int              DATA_W  = 64;
    localparam logic [63:0]     SAT_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rca_64bit.sv
// Combinational 64-bit ripple-carry adder: sum = a + b + cin, cout = carry out.
module rca_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [64:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit; the carry ripples from bit 0 upwards.
    for (genvar i = 0; i < 64; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[64];

endmodule

// File: rtl/rca_acc_64bit.sv
// Registered accumulator around rca_64bit: sums BURST_LEN operand beats
// (each with its own carry-in) and presents the total with a sticky
// overflow flag on a valid/ready output.
// Build macro RCA_ACC_SATURATE_EN: when defined, the accumulator clamps to
// all-ones once any carry-out has been seen in the burst.
module rca_acc_64bit
    import rca_acc_pkg::*;
#(
    parameter  int BURST_LEN = 4,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  beat_cnt
);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]   add_sum;
    logic                add_cout;
    logic                ovf_q;
    logic                live_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;
    logic                last_beat;

    rca_64bit u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (in_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept    = in_valid && in_ready && !clear;
    assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

`ifdef RCA_ACC_SATURATE_EN
    assign acc_next = (add_cout || ovf_q) ? SAT_VAL : add_sum;
`else
    assign acc_next = add_sum;
`endif

    // Holds in_ready low until the first clock edge after reset release.
    // NOTE: every register uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs; clear always forces ACCUM.
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = live_q;
                if (in_valid && live_q && last_beat) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        if (clear) state_d = ACCUM;
    end

    // Accumulator, sticky overflow and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= acc_next;
            ovf_q <= ovf_q | add_cout;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (out_valid && out_ready) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end
    end

    assign out_sum  = acc_q;
    assign out_ovf  = ovf_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_rca_acc_64bit.sv
// Self-checking bench for rca_acc_64bit: directed bursts, a per-cycle
// comparison against a transaction-level model, and literal expectations.
module tb_rca_acc_64bit;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = $clog2(BURST_LEN + 1);

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rca_acc_64bit #(.BURST_LEN(BURST_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Accepted beats of the current burst, each stored as {cin, data}.
    logic [64:0] m_q[$];
    bit          m_live;
    bit          m_done;

    // Exact sum of the burst in wide arithmetic; bits above 63 mean overflow.
    function automatic logic [71:0] burst_total();
        logic [71:0] t = '0;
        foreach (m_q[i]) t += {8'd0, m_q[i][63:0]} + 72'(m_q[i][64]);
        return t;
    endfunction

    function automatic logic [63:0] exp_sum();
        logic [71:0] t = burst_total();
`ifdef RCA_ACC_SATURATE_EN
        if (t[71:64] != 0) return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        return t[63:0];
    endfunction

    function automatic logic exp_ovf();
        logic [71:0] t = burst_total();
        return t[71:64] != 0;
    endfunction

    // Compare outputs mid-cycle, then advance the model with the inputs
    // that the next rising edge will sample.
    initial begin
        m_live = 0;
        m_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_q.delete();
                m_live = 0;
                m_done = 0;
                check("rst_in_ready",  in_ready,  0);
                check("rst_out_valid", out_valid, 0);
                check("rst_beat_cnt",  beat_cnt,  0);
                check("rst_out_sum",   out_sum,   0);
                check("rst_out_ovf",   out_ovf,   0);
            end else begin
                check("cyc_in_ready",  in_ready,  (m_live && !m_done) ? 1 : 0);
                check("cyc_out_valid", out_valid, m_done ? 1 : 0);
                check("cyc_beat_cnt",  beat_cnt,  64'(m_q.size()));
                if (m_done) begin
                    check("cyc_out_sum", out_sum, exp_sum());
                    check("cyc_out_ovf", out_ovf, exp_ovf());
                end
                if (clear) begin
                    m_q.delete();
                    m_done = 0;
                end else if (m_done) begin
                    if (out_ready) begin
                        m_q.delete();
                        m_done = 0;
                    end
                end else if (in_valid && m_live) begin
                    m_q.push_back({in_cin, in_data});
                    if (m_q.size() == BURST_LEN) m_done = 1;
                end
                m_live = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 time unit after a rising edge.
    task automatic send_beat(input logic [63:0] d, input logic c);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("beat_handshake_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_cin   = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [63:0] es, input logic eo);
        int k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"},   out_sum,   es);
        check({name, "_ovf"},   out_ovf,   eo);
        check({name, "_cnt"},   beat_cnt,  BURST_LEN);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        logic [63:0] held;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("in_ready_before_first_edge", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_first_edge", in_ready, 1);

        // Basic burst, result one cycle after the final beat.
        send_beat(64'd10, 1'b0);
        send_beat(64'd35, 1'b0);
        send_beat(64'd23, 1'b0);
        send_beat(64'd132, 1'b0);
        check("t1_valid_next_cycle", out_valid, 1);
        get_result("t1", 64'd200, 1'b0);

        // Carry-in added on every beat.
        send_beat(64'd3846, 1'b1);
        send_beat(64'd9654, 1'b1);
        send_beat(64'd866945, 1'b1);
        send_beat(64'd3324752, 1'b1);
        get_result("t2", 64'd4205201, 1'b0);

        // Overflow: wrap (default) or saturate.
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_beat(64'd1, 1'b0);
        send_beat(64'd0, 1'b0);
        send_beat(64'd0, 1'b0);
`ifdef RCA_ACC_SATURATE_EN
        get_result("t3", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
        get_result("t3", 64'd0, 1'b1);
`endif

        // Backpressure: result held, no beats consumed.
        send_beat(64'd100, 1'b0);
        send_beat(64'd200, 1'b0);
        send_beat(64'd300, 1'b0);
        send_beat(64'd400, 1'b0);
        held     = out_sum;
        in_valid = 1'b1;
        in_data  = 64'd77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_held", out_sum, held);
        end
        check("bp_sum_value", out_sum, 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(64'd1, 1'b0);
        send_beat(64'd2, 1'b0);
        send_beat(64'd3, 1'b0);
        send_beat(64'd4, 1'b0);
        get_result("t4", 64'd10, 1'b0);

        // Clear after two beats drops the partial sum and a concurrent beat.
        send_beat(64'd6223372036854775808, 1'b0);
        send_beat(64'd38701384792384, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'd999;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_beat_cnt", beat_cnt, 0);
        for (int i = 0; i < 4; i++) send_beat(64'd1, 1'b0);
        get_result("t5", 64'd4, 1'b0);

        // Asynchronous reset mid-burst.
        send_beat(64'd7, 1'b0);
        send_beat(64'd8, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_beat_cnt",  beat_cnt,  0);
        check("rst_mid_in_ready",  in_ready,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while a result is pending.
        for (int i = 0; i < 4; i++) send_beat(64'd9, 1'b0);
        check("pre_rst_done_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_beat_cnt",  beat_cnt,  0);
        check("rst_done_in_ready",  in_ready,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(64'd5, 1'b0);
        get_result("t6", 64'd20, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rca_acc_64bit.md
Name: rca_acc_64bit

Overview:
- Registered accumulator stage wrapped around the existing combinational 64-bit ripple-carry adder.
- Consumes a stream of 64-bit operands over a valid/ready handshake and sums BURST_LEN of them, adding each beat's carry-in.
- Presents the total, with a sticky overflow flag, on a valid/ready output; it is the sequential feeder/consumer for the adder.

Parameters:
- BURST_LEN, 4, operands accumulated per result; legal range 1..255.
- CNT_W, $clog2(BURST_LEN+1), derived localparam; width of beat_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort/flush; highest priority after reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  64  operand, unsigned.
- in_cin  in  1  carry-in added with this beat.
- out_valid  out  1  burst result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  64  accumulated sum, modulo 2^64.
- out_ovf  out  1  a carry-out occurred during the burst.
- beat_cnt  out  CNT_W  beats accepted in the current burst.

Behaviour:
- Datapath: one rca_64bit instance with a=acc, b=in_data, cin=in_cin. Its sum and cout are registered only on an accepted beat (in_valid && in_ready).
- Reset (rst_n=0, asynchronous):
  - acc=0, beat_cnt=0, ovf=0, state=ACCUM.
  - out_valid=0, in_ready=0 while reset is asserted; in_ready=1 from the first clock after deassertion.
  - out_sum=0, out_ovf=0.
- FSM ACCUM:
  - in_ready=1, out_valid=0.
  - On an accepted beat: acc<=sum, ovf<=ovf|cout, beat_cnt++.
  - If the accepted beat is beat number BURST_LEN, go to DONE.
- FSM DONE:
  - in_ready=0, out_valid=1; out_sum=acc and out_ovf=ovf, held stable while out_ready=0.
  - On out_ready=1: acc<=0, ovf<=0, beat_cnt<=0, go to ACCUM.
  - in_ready returns to 1 the next cycle. There is no same-cycle bypass, so throughput is BURST_LEN+1 cycles per result minimum.
- Latency: out_valid rises the cycle after the final beat is accepted.
- clear=1 at a clock edge, in either state:
  - acc=0, ovf=0, beat_cnt=0, state=ACCUM.
  - Any pending result is discarded and a simultaneous input beat is dropped.
  - clear wins over simultaneous out_ready or in_valid.
- out_valid and out_sum never change while out_valid=1 and out_ready=0, except on clear or reset.
- Input beats with in_valid=0 leave all state unchanged.
- Wrap-around:
  - The sum is modulo 2^64; any cout=1 sets ovf for the remainder of the burst.
  - beat_cnt never exceeds BURST_LEN.
- BURST_LEN=1: every accepted beat produces a result of in_data+in_cin.
- Reset mid-burst or mid-DONE: immediate return to reset values; the partial result is lost.

Optional Feature:
- Macro: RCA_ACC_SATURATE_EN.
- Defined: when an accepted beat produces cout=1, or ovf is already set, acc<=64'hFFFF_FFFF_FFFF_FFFF. out_sum therefore saturates at all-ones; out_ovf behaves the same.
- Undefined: the sum wraps modulo 2^64; out_ovf is the only indication of overflow.

Decomposition:
- Package rca_acc_pkg:
  - state enum {ACCUM, DONE}.
  - localparam DATA_W=64.
  - localparam SAT_VAL=64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module: the existing rca_64bit, instantiated unchanged, one instance. No other sub-modules.

Test Plan:
- Reset then burst 10, 35, 23, 132 with cin=0 and out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=200, out_ovf=0, beat_cnt=4 in DONE.
- Burst 3846, 9654, 866945, 3324752 with cin=1 each -> out_sum=4205201, out_ovf=0.
- Burst 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0 with cin=0 ->
  - default build: out_sum=0, out_ovf=1.
  - RCA_ACC_SATURATE_EN build: out_sum=64'hFFFF_FFFF_FFFF_FFFF, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE while driving in_valid=1 -> in_ready=0, out_sum stable, no beats consumed. Then out_ready=1 -> next burst starts from acc=0.
- Assert clear after 2 beats (6223372036854775808, 38701384792384), then run a full burst of 1, 1, 1, 1 with cin=0 -> out_sum=4, no out_valid before that result.
- Pulse rst_n low asynchronously mid-burst and in DONE -> out_valid=0 and beat_cnt=0 immediately, in_ready=0 during reset. Next full burst of 5, 5, 5, 5 gives out_sum=20.
